// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction fetch unit.
package mips_pkg;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   // Bit positions of the opcode field inside an instruction word
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;

   // PC value loaded by reset unless the instance overrides it
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Extracts the opcode field that feeds the control unit
   function automatic logic [5:0] getOpcode(input logic [31:0] word);
      return word[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/mips_pc_reg.sv
// Program counter register with its +4 incrementer and branch redirect mux.
// pc_next_o exposes the value the PC takes on the coming edge so the fetch
// sequencer can launch a request at the new address without an extra cycle.
module mips_pc_reg
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] target_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] pc_next_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   // Redirect wins over sequential increment; the add wraps modulo 2^ADDR_W
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = target_i;
      end else if (inc_i) begin
         pc_d = pc_q + ADDR_W'(4);
      end
   end

   // PC storage, returned to RESET_PC whenever reset is low
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_next_o = pc_d;

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch unit: requests instruction words from memory, holds
// the fetched word for the decoder and follows branch redirects, dropping any
// response that belongs to a request made before the redirect.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds a sticky misalign_err
// output and halts fetching on a misaligned branch target until reset; without
// it the low two target bits are simply cleared.
module mips_fetch_unit
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              CLK,
   input  logic              Reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              stall,
   output logic              instr_valid,
   output logic [31:0]       instr,
   output logic [5:0]        Opcode,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic              misalign_err
`endif
);

   fetch_state_e      state_q;
   logic              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic              valid_q;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] pcOut_q;

   logic [ADDR_W-1:0] targetEff;
   logic [ADDR_W-1:0] pcNext;
   logic              haltNow;
   logic              pcLoad;
   logic              pcInc;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic err_q;
   logic misalign;

   assign misalign  = branch_taken && (branch_target[1:0] != 2'b00);
   assign haltNow   = misalign || err_q;
   assign targetEff = branch_target;
`else
   assign haltNow   = 1'b0;
   assign targetEff = branch_target & ~ADDR_W'(3);
`endif

   assign pcLoad = branch_taken && !haltNow;
   assign pcInc  = (state_q == FETCH) && imem_ready && !branch_taken;

   mips_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .CLK       (CLK),
      .Reset     (Reset),
      .load_i    (pcLoad),
      .target_i  (targetEff),
      .inc_i     (pcInc),
      .pc_next_o (pcNext)
   );

   // Fetch sequencer with registered memory-request and instruction outputs.
   // Every new request is launched at pcNext so a redirect seen on the same
   // edge is honoured immediately; a request already on the bus keeps its
   // address until memory answers, and answers to stale requests are dropped.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         instr_q <= '0;
         pcOut_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
         if (misalign) begin
            err_q <= 1'b1;
         end
`endif
         if (haltNow) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= FETCH;
                  req_q   <= 1'b1;
                  addr_q  <= pcNext;
               end
               FETCH: begin
                  if (branch_taken) begin
                     valid_q <= 1'b0;
                     if (imem_ready) begin
                        addr_q <= pcNext;
                     end else begin
                        state_q <= DRAIN;
                     end
                  end else if (imem_ready) begin
                     instr_q <= imem_rdata;
                     pcOut_q <= addr_q;
                     valid_q <= 1'b1;
                     req_q   <= 1'b0;
                     state_q <= HOLD;
                  end
               end
               HOLD: begin
                  if (branch_taken || !stall) begin
                     valid_q <= 1'b0;
                     req_q   <= 1'b1;
                     addr_q  <= pcNext;
                     state_q <= FETCH;
                  end
               end
               DRAIN: begin
                  if (imem_ready) begin
                     addr_q  <= pcNext;
                     state_q <= FETCH;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  req_q   <= 1'b0;
                  valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign Opcode      = getOpcode(instr_q);
   assign pc_out      = pcOut_q;
   assign pc_plus4    = pcOut_q + ADDR_W'(4);
`ifdef FETCH_MISALIGN_CHECK_EN
   assign misalign_err = err_q;
`endif

endmodule

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 Parameter ADDR_W, 32, width of PC and instruction-memory address.
REQ-002 Parameter RESET_PC, 32'h0000_0000, PC loaded by reset.
REQ-003 Port CLK  input  1  single clock; all state updates on posedge.
REQ-004 Port Reset  input  1  asynchronous active-low reset.
REQ-005 Port imem_req  output  1  fetch request to instruction memory.
REQ-006 Port imem_addr  output  ADDR_W  word-aligned fetch address.
REQ-007 Port imem_ready  input  1  memory returns imem_rdata this cycle.
REQ-008 Port imem_rdata  input  32  fetched instruction word.
REQ-009 Port branch_taken  input  1  redirect from execute (Branch AND zero).
REQ-010 Port branch_target  input  ADDR_W  redirect PC.
REQ-011 Port stall  input  1  downstream cannot accept the held instruction.
REQ-012 Port instr_valid  output  1  instr/Opcode/pc_out hold a valid instruction.
REQ-013 Port instr  output  32  registered instruction word.
REQ-014 Port Opcode  output  6  instr[31:26], the input to the control unit.
REQ-015 Port pc_out  output  ADDR_W  address of the held instruction.
REQ-016 Port pc_plus4  output  ADDR_W  pc_out + 4, for branch-target adders.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, HOLD and DRAIN.
REQ-018 IDLE SHALL go to FETCH unconditionally on the next clock.
REQ-019 In FETCH, imem_req = 1 and imem_addr = pc; both SHALL stay stable until imem_ready.
REQ-020 In FETCH with imem_ready = 1 and no branch: capture instr/pc_out, set instr_valid, pc <= pc + 4, go HOLD; latency from ready to instr_valid SHALL be 1 cycle.
REQ-021 In HOLD, stall = 1 SHALL hold all outputs unchanged; stall = 0 SHALL consume the instruction, clear instr_valid next cycle and go FETCH.
REQ-022 branch_taken = 1 in any state SHALL load pc <= branch_target and clear instr_valid next cycle; branch SHALL take priority over stall and imem_ready.
REQ-023 branch_taken in FETCH SHALL go DRAIN, holding imem_req and the old imem_addr until imem_ready; that response SHALL be discarded, then go FETCH at the new pc.
REQ-024 branch_taken in FETCH in the same cycle as imem_ready SHALL discard the data and go directly to FETCH.
REQ-025 branch_taken in DRAIN SHALL update pc only; draining SHALL continue.
REQ-026 PC arithmetic SHALL be modulo 2^ADDR_W; 0xFFFF_FFFC + 4 wraps to 0.
REQ-027 imem_req SHALL be 0 in IDLE and HOLD.

Reset
REQ-028 Reset low SHALL immediately force state IDLE, pc = RESET_PC, imem_req = 0, instr_valid = 0, instr = 0, Opcode = 0, pc_out = 0, pc_plus4 = 4.
REQ-029 Reset during FETCH/DRAIN SHALL abandon the outstanding request; a late imem_ready after reset SHALL be ignored in IDLE.

Configuration
REQ-030 With FETCH_MISALIGN_CHECK_EN defined: add output misalign_err (1 bit, reset 0), set sticky when branch_taken has branch_target[1:0] != 0; the FSM halts in IDLE until reset.
REQ-031 Without FETCH_MISALIGN_CHECK_EN: no misalign_err port; branch_target[1:0] SHALL be forced to 0.

Structure
REQ-032 Package mips_pkg SHALL hold the FSM state enum, the OPCODE_MSB/LSB constants (31/26) and the RESET_PC default.
REQ-033 Sub-module mips_pc_reg SHALL hold the PC register, the +4 incrementer and the redirect mux; the FSM SHALL stay in mips_fetch_unit.

Verification
REQ-034 Reset release, imem_ready tied 1, rdata 0x8C22_0004 -> imem_addr 0x0, instr_valid on cycle 3, Opcode = 35, pc_plus4 = 4.
REQ-035 stall = 1 for 5 cycles in HOLD -> instr/pc_out constant, imem_req = 0 throughout, next fetch at 0x4 after stall drops.
REQ-036 Memory latency 3 cycles, branch_taken to 0x100 in cycle 2 of wait -> old response discarded, next imem_addr = 0x100, no instr_valid for the discarded word.
REQ-037 branch_taken and imem_ready in the same FETCH cycle, target 0x40 -> data dropped, next FETCH addr 0x40.
REQ-038 Fetch at 0xFFFF_FFFC -> pc wraps to 0x0; branch_target 0x102 -> misalign_err = 1 with the macro, fetch at 0x100 without it.
